pipe_hazard_ctrl: RTL

- Pipeline sequencer for the RSA decryption ASIP.
- Drives the enables and flushes of the PC, the IF/ID register and the ID/EX register.
- Detects load-use hazards, applies taken-branch flushes, and holds the front end while the multi-cycle modular unit (modexp/modmul) runs.
- Provides a timeout-protected busy FSM and a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_hazard_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the RSA decryption ASIP: load-use stalls, branch
// flushes, and front-end hold while the multi-cycle modular unit runs.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_W      = 5,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MC_TIMEOUT = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             id_mc_op,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mc_done,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mc_start,
  output logic             mc_busy,
  output logic             mc_error,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned TO_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_BUSY = 2'd1,
    ERROR   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [TO_W-1:0]   to_cnt;
  logic [TO_W-1:0]   to_cnt_nxt;
  logic              load_use;

  // EX load writes a register the ID instruction is about to read
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  // State and modular-unit timeout counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= RUN;
      to_cnt <= '0;
    end else begin
      state  <= state_nxt;
      to_cnt <= to_cnt_nxt;
    end
  end

  // Next state and pipeline control; everything forced low while in reset
  always_comb begin
    state_nxt   = state;
    to_cnt_nxt  = to_cnt;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    mc_start    = 1'b0;
    mc_busy     = 1'b0;
    mc_error    = 1'b0;
    if (!reset) begin
      unique case (state)
        RUN: begin
          if (ex_branch_taken) begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            id_ex_flush = 1'b1;
          end else if (id_mc_op) begin
            mc_start    = 1'b1;
            id_ex_flush = 1'b1;
            state_nxt   = MC_BUSY;
            to_cnt_nxt  = '0;
          end else begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
          end
        end
        MC_BUSY: begin
          mc_busy = 1'b1;
          if (mc_done) begin
            // Held mc instruction advances into EX this cycle
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            state_nxt = RUN;
          end else begin
            id_ex_flush = 1'b1;
            to_cnt_nxt  = to_cnt + TO_W'(1);
            if (to_cnt == TO_W'(MC_TIMEOUT - 1)) state_nxt = ERROR;
          end
        end
        ERROR: begin
          mc_error    = 1'b1;
          id_ex_flush = 1'b1;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  // Saturating count of cycles with the PC held
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (!pc_en && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule
